// File: rtl/async_fifo.sv
// Single-clock Gray-pointer FIFO that keeps the dual-domain FIFO's port behaviour,
// including 2-flop pointer synchronizers and their pessimistic flag latency.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 4,
  parameter int MEM_DEPTH  = 8
) (
  input  logic                  W_CLK,
  input  logic                  W_RST_N,
  input  logic                  W_INC_EN,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  output logic                  W_FULL,
  input  logic                  R_INC_EN,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  R_EMPTY
);

  localparam int AW = BUS_WIDTH - 1;
  localparam logic [BUS_WIDTH-1:0] PTR_ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [BUS_WIDTH-1:0] bin2gray(input logic [BUS_WIDTH-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [BUS_WIDTH-1:0]  wbin_q, wbin_d, wgray_q, wgray_d;
  logic [BUS_WIDTH-1:0]  rbin_q, rbin_d, rgray_q, rgray_d;
  logic [BUS_WIDTH-1:0]  wq1_q, wq2_q, rq1_q, rq2_q;
  logic                  wr_en_s, rd_en_s, full_s, empty_s;

  assign wr_en_s = W_INC_EN & ~full_s;
  assign rd_en_s = R_INC_EN & ~empty_s;

  // Pointer next-state: each side advances only when its own flag allows it.
  always_comb begin
    wbin_d = wbin_q;
    rbin_d = rbin_q;
    if (wr_en_s) begin
      wbin_d = wbin_q + PTR_ONE;
    end else begin
      wbin_d = wbin_q;
    end
    if (rd_en_s) begin
      rbin_d = rbin_q + PTR_ONE;
    end else begin
      rbin_d = rbin_q;
    end
    wgray_d = bin2gray(wbin_d);
    rgray_d = bin2gray(rbin_d);
  end

  // Pointers, Gray copies and cross-side synchronizers.
  always_ff @(posedge W_CLK) begin
    if (!W_RST_N) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rbin_q  <= '0;
      rgray_q <= '0;
      wq1_q   <= '0;
      wq2_q   <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      wq1_q   <= wgray_q;
      wq2_q   <= wq1_q;
      rq1_q   <= rgray_q;
      rq2_q   <= rq1_q;
    end
  end

  // Storage array; reset clears every word so stale data never reaches R_DATA.
  always_ff @(posedge W_CLK) begin
    if (!W_RST_N) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wbin_q[AW-1:0]] <= W_DATA;
    end
  end

  // Full when the write pointer is one lap ahead of the synchronized read pointer.
  assign full_s  = (wgray_q == {~rq2_q[BUS_WIDTH-1:BUS_WIDTH-2], rq2_q[BUS_WIDTH-3:0]});
  assign empty_s = (rgray_q == wq2_q);

  assign W_FULL  = full_s;
  assign R_EMPTY = empty_s;
  assign R_DATA  = mem_q[rbin_q[AW-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo: reset, burst/drain, full, wrap,
// steady simultaneous access and mid-operation reset.
module tb_async_fifo;

  logic       clk;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       full;
  logic       rinc;
  logic [7:0] rdata;
  logic       empty;

  int vectors;
  int miscompares;

  async_fifo #(
    .DATA_WIDTH(8),
    .BUS_WIDTH (4),
    .MEM_DEPTH (8)
  ) dut (
    .W_CLK   (clk),
    .W_RST_N (rst_n),
    .W_INC_EN(winc),
    .W_DATA  (wdata),
    .W_FULL  (full),
    .R_INC_EN(rinc),
    .R_DATA  (rdata),
    .R_EMPTY (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] burst [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    burst[0] = 8'hA2; burst[1] = 8'h02; burst[2] = 8'h04;
    burst[3] = 8'h06; burst[4] = 8'h08; burst[5] = 8'h0A;

    // Reset with requests asserted; they must be ignored.
    rst_n = 1'b0; winc = 1'b1; wdata = 8'h77; rinc = 1'b1;
    tick();
    tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_empty", {31'd0, empty}, 32'd1);

    // Burst of six writes; empty falls two edges after the first.
    for (int i = 0; i < 6; i++) begin
      winc = 1'b1; wdata = burst[i];
      tick();
      if (i < 2) check("burst_empty_lag", {31'd0, empty}, 32'd1);
      if (i == 2) begin
        check("burst_empty_fall", {31'd0, empty}, 32'd0);
        check("burst_first_data", {24'd0, rdata}, 32'h0000_00A2);
      end
    end
    winc = 1'b0;
    tick();
    tick();
    rinc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("drain_data",  {24'd0, rdata}, {24'd0, burst[i]});
      check("drain_empty", {31'd0, empty}, 32'd0);
      tick();
    end
    check("drain_empty_rise", {31'd0, empty}, 32'd1);
    tick();
    check("drain_no_extra", {31'd0, empty}, 32'd1);
    rinc = 1'b0;
    tick();
    tick();

    // Fill to full, drop a ninth write, pop one and watch full fall late.
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wdata = 8'h10 + 8'(i);
      tick();
      check("fill_full", {31'd0, full}, (i == 7) ? 32'd1 : 32'd0);
    end
    wdata = 8'hFF;
    tick();
    check("fill_full_hold", {31'd0, full}, 32'd1);
    winc = 1'b0;
    tick();
    check("fill_head", {24'd0, rdata}, 32'h0000_0010);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("pop_full_lag0", {31'd0, full}, 32'd1);
    check("pop_next_data", {24'd0, rdata}, 32'h0000_0011);
    tick();
    check("pop_full_lag1", {31'd0, full}, 32'd1);
    tick();
    check("pop_full_fall", {31'd0, full}, 32'd0);
    rinc = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("fill_drain_data", {24'd0, rdata}, 32'h10 + 32'(i));
      tick();
    end
    check("fill_drain_empty", {31'd0, empty}, 32'd1);
    rinc = 1'b0;
    tick();

    // Three fill/drain laps across the wrap bit.
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        winc = 1'b1; wdata = 8'h30 + 8'(c * 16 + i);
        tick();
      end
      winc = 1'b0;
      check("wrap_full", {31'd0, full}, 32'd1);
      tick();
      tick();
      rinc = 1'b1;
      for (int i = 0; i < 8; i++) begin
        check("wrap_data",  {24'd0, rdata}, 32'h30 + 32'(c * 16 + i));
        check("wrap_empty", {31'd0, empty}, 32'd0);
        tick();
      end
      rinc = 1'b0;
      check("wrap_empty_rise", {31'd0, empty}, 32'd1);
    end
    tick();
    tick();

    // Steady occupancy of four with write and read every cycle.
    for (int i = 0; i < 4; i++) begin
      winc = 1'b1; wdata = 8'h80 + 8'(i);
      tick();
    end
    winc = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'h84 + 8'(i);
      check("simul_data",  {24'd0, rdata}, 32'h80 + 32'(i));
      check("simul_empty", {31'd0, empty}, 32'd0);
      check("simul_full",  {31'd0, full},  32'd0);
      tick();
    end
    winc = 1'b0; rinc = 1'b0;
    tick();
    tick();
    check("simul_head", {24'd0, rdata}, 32'h0000_0094);

    // Fifth word, then a one-cycle reset mid-operation.
    winc = 1'b1; wdata = 8'h98;
    tick();
    winc = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_full",  {31'd0, full},  32'd0);
    check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    winc = 1'b1; wdata = 8'h55;
    tick();
    winc = 1'b0;
    check("mid_rst_lag0", {31'd0, empty}, 32'd1);
    tick();
    check("mid_rst_lag1", {31'd0, empty}, 32'd1);
    tick();
    check("mid_rst_visible", {31'd0, empty}, 32'd0);
    check("mid_rst_data",    {24'd0, rdata}, 32'h0000_0055);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("mid_rst_pop_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
